vram_arbiter: RTL
=================

# vram_arbiter

Arbitrates the single-port video RAM between two requesters: the scanout path, which fetches pixels for the VGA timing generator, and the MCU write path, which stores pixel data decoded from the MCU bus. Scanout always wins because a late pixel is a visible glitch. MCU writes are buffered in a small FIFO and drained in cycles the scanout leaves idle, so the MCU bus never has to know the VGA timing. The block sits between `mcu_bus`/`vga` and the RAM macro, in the system clock domain.

## Interface
Parameters:
- `ADDR_W`, 16: VRAM word address width.
- `DATA_W`, 12: pixel width, RGB 4:4:4.
- `FIFO_DEPTH`, 4: write FIFO entries; a power of two, at least 2.
- `STARVE_LIMIT`, 1024: consecutive denied cycles before the starvation flag sets.

Ports:
- `clock` in 1: single clock for the whole block.
- `reset_n` in 1: reset, synchronous, active-low.
- `scan_req` in 1: scanout read request. Always accepted.
- `scan_addr` in ADDR_W: scanout read address.
- `scan_rvalid` out 1: `scan_rdata` is valid this cycle.
- `scan_rdata` out DATA_W: pixel returned to scanout.
- `wr_valid` in 1: MCU write offered.
- `wr_ready` out 1: FIFO can accept a write.
- `wr_addr` in ADDR_W: MCU write address.
- `wr_data` in DATA_W: MCU write data.
- `mem_en` out 1: RAM access strobe.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM read data, valid 1 cycle after a read with `mem_en` high.
- `fifo_level` out clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `wr_starved` out 1: sticky starvation flag.
- `status_clear` in 1: clears `wr_starved`.

## Operation
- Write FIFO:
  - Push when `wr_valid && wr_ready`.
  - `wr_ready` = !full, from the registered count.
  - No pass-through: a write never goes to the RAM in the cycle it is pushed.
- Grant, decided once per cycle from the current inputs and FIFO state:
  - GNT_SCAN if `scan_req`.
  - Otherwise GNT_WRITE if the FIFO is non-empty; this pops the head.
  - Otherwise GNT_NONE.
- The grant is registered into `mem_*`:
  - GNT_SCAN: `mem_en`=1, `mem_we`=0, `mem_addr`=`scan_addr`.
  - GNT_WRITE: `mem_en`=1, `mem_we`=1, `mem_addr`/`mem_wdata` = FIFO head.
  - GNT_NONE: `mem_en`=0, `mem_we`=0. `mem_addr`/`mem_wdata` hold their previous values.
- Read tracking: a 2-stage valid shift register follows each scan read. `scan_rdata` is `mem_rdata` registered.
- Writes drain in FIFO order; write order to the RAM is never changed.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and GNT_SCAN is granted.
  - Resets to 0 on any GNT_WRITE or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - Reaching STARVE_LIMIT sets `wr_starved`.
- `status_clear` clears `wr_starved`. If `status_clear` and a set condition occur in the same cycle, set wins.

## Timing
- Reset values: all outputs 0, including `wr_ready`, `fifo_level` and `wr_starved`. The FIFO is flushed and the starvation counter is 0.
- `wr_ready` goes to 1 in the first cycle after `reset_n` deasserts.
- Scan latency is exactly 3 cycles with no jitter:
  - `scan_req` at edge N.
  - `mem_en` at N+1.
  - `mem_rdata` at N+2.
  - `scan_rvalid`/`scan_rdata` at N+3.
- Back-to-back scan requests give back-to-back `scan_rvalid`.
- Write latency, push to `mem_we`:
  - Minimum 2 cycles: push at N, head grant at N+1, `mem_we` at N+2.
  - Unbounded while `scan_req` is held high.
- Same-cycle push and pop when not full: count unchanged. When full: no push, pop only.
- Scan read and a pending write to the same address: the read returns the pre-write data.
- Reset mid-operation:
  - In-flight reads are dropped; no `scan_rvalid` pulse follows reset.
  - Queued writes are discarded.
- Counters wrap: FIFO pointers wrap modulo FIFO_DEPTH, with a separate count for full/empty.

## Structure
- Shared package `msgpu_pkg`:
  - Default `ADDR_W`/`DATA_W`.
  - Grant enum: GNT_NONE, GNT_SCAN, GNT_WRITE.
  - Scan latency constant `SCAN_LAT`=3.
- One sub-module: `vram_write_fifo`, a synchronous FIFO with push/pop/level/full/empty.
- The arbitration, read-valid pipeline and starvation logic stay in `vram_arbiter`.

## Test plan
- Reset: reset held for 5 cycles with `scan_req`/`wr_valid` toggling -> all outputs 0. `wr_ready`=1 one cycle after release.
- Scan latency: `scan_req` with addresses 0x0000..0x0009 on consecutive cycles, model RAM preloaded with addr&0xFFF -> 10 consecutive `scan_rvalid` starting at N+3, with matching data.
- Idle drain: 3 writes (0x0100/0xABC, 0x0101/0x123, 0x0102/0xFFF) with `scan_req`=0 -> `mem_we` on 3 cycles in order. `fifo_level` returns to 0.
- Full and back-pressure: `scan_req`=1 continuously, 6 writes offered -> 4 accepted, `wr_ready`=0, `fifo_level`=4. Drop `scan_req` -> 4 writes drain, `wr_ready` high again.
- Starvation: STARVE_LIMIT=8, 1 write queued under continuous `scan_req` -> `wr_starved` sets after 8 denied cycles. `status_clear` clears it; a set in the same cycle as clear keeps it 1.
- Reset mid-flight: `reset_n` low one cycle after a `scan_req` with 2 writes queued -> no `scan_rvalid` pulse, no `mem_we`, `fifo_level`=0.

Source files
------------

// File: rtl/msgpu_pkg.sv
// Shared definitions for the msgpu video path.
//   ADDR_W_DEF / DATA_W_DEF : default VRAM address and pixel widths
//   SCAN_LAT                : scanout request-to-data latency in cycles
//   gnt_e                   : per-cycle VRAM port grant
package msgpu_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 12;
  localparam int SCAN_LAT   = 3;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_SCAN,
    GNT_WRITE
  } gnt_e;
endpackage

// File: rtl/vram_write_fifo.sv
// Synchronous FIFO buffering MCU writes until the VRAM port is free.
//   clock, reset_n : clock, synchronous active-low reset (flushes contents)
//   push, din      : enqueue (ignored when full)
//   pop, dout      : dequeue (ignored when empty); dout shows the head
//   level          : occupancy, 0..DEPTH
//   full, empty    : derived from level, not from the pointers
module vram_write_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign full    = (level == (PTR_W+1)'(DEPTH));
  assign empty   = (level == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; the pointers and level define what is valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (PTR_W+1)'(1);
        2'b01:   level <= level - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads always win, MCU writes are queued
// and drained in idle cycles.
//   clock, reset_n           : clock, synchronous active-low reset
//   scan_req/scan_addr       : scanout read request (always accepted)
//   scan_rvalid/scan_rdata   : read data, fixed SCAN_LAT cycles after request
//   wr_valid/wr_ready/...    : MCU write handshake into the FIFO
//   mem_*                    : registered RAM port
//   fifo_level               : FIFO occupancy
//   wr_starved/status_clear  : sticky starvation flag and its clear
module vram_arbiter
  import msgpu_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          scan_req,
  input  logic [ADDR_W-1:0]             scan_addr,
  output logic                          scan_rvalid,
  output logic [DATA_W-1:0]             scan_rdata,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          wr_starved,
  input  logic                          status_clear
);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] LIMIT = SC_W'(STARVE_LIMIT);

  gnt_e                     gnt;
  logic                     alive;
  logic                     fifo_full, fifo_empty;
  logic                     push, pop;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [SC_W-1:0]          starve_cnt;
  logic                     starve_hit;
  logic [SCAN_LAT-2:0]      vld_pipe;

  // alive keeps wr_ready low during reset and for the release cycle.
  assign wr_ready    = alive & ~fifo_full;
  assign push        = wr_valid & wr_ready;
  assign pop         = (gnt == GNT_WRITE);
  assign scan_rvalid = vld_pipe[SCAN_LAT-2];

  always_comb begin
    gnt = GNT_NONE;
    if (scan_req)         gnt = GNT_SCAN;
    else if (!fifo_empty) gnt = GNT_WRITE;
  end

  // Set fires only on the step into the limit, so a clear can stick while
  // the counter sits saturated.
  assign starve_hit = (gnt == GNT_SCAN) & ~fifo_empty &
                      (starve_cnt == LIMIT - SC_W'(1));

  vram_write_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     ({wr_addr, wr_data}),
    .dout    (head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      alive      <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      vld_pipe   <= '0;
      scan_rdata <= '0;
      starve_cnt <= '0;
      wr_starved <= 1'b0;
    end else begin
      alive  <= 1'b1;
      mem_en <= (gnt != GNT_NONE);
      mem_we <= (gnt == GNT_WRITE);
      case (gnt)
        GNT_SCAN:  mem_addr <= scan_addr;
        GNT_WRITE: {mem_addr, mem_wdata} <= head;
        default:   ;
      endcase

      // Stage 0 marks the cycle mem_rdata is valid; last stage is the output.
      vld_pipe <= {vld_pipe[SCAN_LAT-3:0], mem_en & ~mem_we};
      if (vld_pipe[0]) scan_rdata <= mem_rdata;

      if (fifo_empty || gnt == GNT_WRITE)
        starve_cnt <= '0;
      else if (gnt == GNT_SCAN && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + SC_W'(1);

      if (starve_hit)        wr_starved <= 1'b1;
      else if (status_clear) wr_starved <= 1'b0;
    end
  end
endmodule
